// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer that drives an external ALU from a 4-entry register file.
// Instructions are accepted in IDLE, execute in EXEC and retire (done pulse) in WB.
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [1:0]       in_rd,
    input  logic [1:0]       in_rs1,
    input  logic [1:0]       in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    output logic [2:0]       alu_ctrl2,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    input  logic             alu_zero,
    output logic             done,
    output logic             flag_c,
    output logic             flag_z,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_CMP = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;

    localparam logic [1:0] CTRL_ADD = 2'b00;
    localparam logic [1:0] CTRL_SUB = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       r_op;
    logic [1:0]       r_rd;
    logic [1:0]       r_rs1;
    logic [1:0]       r_rs2;
    logic [WIDTH-1:0] r_imm;

    logic [WIDTH-1:0] r_regs [4];
    logic             r_flag_c;
    logic             r_flag_z;

    logic             w_accept;
    logic             w_reg_we;
    logic             w_flag_we;
    logic [WIDTH-1:0] w_reg_wdata;
    logic [WIDTH-1:0] w_src1;
    logic [WIDTH-1:0] w_src2;

    // Operands come from the register file before the EXEC-edge write, so rd==rs reads the old value.
    assign w_src1   = r_regs[r_rs1];
    assign w_src2   = r_regs[r_rs2];
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        done        = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = CTRL_ADD;
        alu_ctrl2   = SEL_AND;
        w_reg_we    = 1'b0;
        w_flag_we   = 1'b0;
        w_reg_wdata = alu_y;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_WB;
                case (r_op)
                    OP_ADD: begin
                        alu_a     = w_src1;
                        alu_b     = w_src2;
                        alu_ctrl2 = SEL_ADD;
                        w_reg_we  = 1'b1;
                        w_flag_we = 1'b1;
                    end
                    OP_SUB, OP_CMP: begin
                        alu_a     = w_src1;
                        alu_b     = w_src2;
                        alu_ctrl  = CTRL_SUB;
                        alu_ctrl2 = SEL_ADD;
                        w_reg_we  = (r_op == OP_SUB);
                        w_flag_we = 1'b1;
                    end
                    OP_AND: begin
                        alu_a     = w_src1;
                        alu_b     = w_src2;
                        alu_ctrl2 = SEL_AND;
                        w_reg_we  = 1'b1;
                        w_flag_we = 1'b1;
                    end
                    OP_OR: begin
                        alu_a     = w_src1;
                        alu_b     = w_src2;
                        alu_ctrl2 = SEL_OR;
                        w_reg_we  = 1'b1;
                        w_flag_we = 1'b1;
                    end
                    OP_MOV: begin
                        alu_a     = w_src1;
                        alu_ctrl2 = SEL_ADD;
                        w_reg_we  = 1'b1;
                        w_flag_we = 1'b1;
                    end
                    OP_LDI: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = r_imm;
                    end
                    default: begin
                    end
                endcase
            end
            S_WB: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The instruction latch only holds data; reset forces IDLE so a stale value is never used.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op  <= in_op;
            r_rd  <= in_rd;
            r_rs1 <= in_rs1;
            r_rs2 <= in_rs2;
            r_imm <= in_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            if (w_reg_we) begin
                r_regs[r_rd] <= w_reg_wdata;
            end
            if (w_flag_we) begin
                r_flag_c <= alu_cout;
                r_flag_z <= alu_zero;
            end
        end
    end

    assign flag_c   = r_flag_c;
    assign flag_z   = r_flag_z;
    assign dbg_data = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, directed scenarios and random instructions
// checked against an arithmetic register-file model.
module tb_alu_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [1:0]       in_rd;
    logic [1:0]       in_rs1;
    logic [1:0]       in_rs2;
    logic [WIDTH-1:0] in_imm;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_ctrl;
    logic [2:0]       alu_ctrl2;
    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;
    logic             alu_zero;
    logic             done;
    logic             flag_c;
    logic             flag_z;
    logic [1:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_ctrl2(alu_ctrl2),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_zero(alu_zero),
        .done(done), .flag_c(flag_c), .flag_z(flag_z),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Simple ALU: adder with optional invert/carry-in, plus AND/OR result selects.
    logic [WIDTH:0] w_sum;
    assign w_sum    = {1'b0, alu_a} + {1'b0, alu_b ^ {WIDTH{alu_ctrl[0]}}} + {{WIDTH{1'b0}}, alu_ctrl[0]};
    assign alu_y    = (alu_ctrl2 == 3'b000) ? (alu_a & alu_b) :
                      (alu_ctrl2 == 3'b001) ? (alu_a | alu_b) : w_sum[WIDTH-1:0];
    assign alu_cout = w_sum[WIDTH];
    assign alu_zero = (alu_y == '0);

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int m_r [4];
    int m_c;
    int m_z;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_c = 0;
        m_z = 0;
    endtask

    task automatic model_step(input int op, input int rd, input int rs1, input int rs2, input int imm);
        int a = m_r[rs1];
        int b = m_r[rs2];
        int res = 0;
        case (op)
            0: begin res = a + b; m_c = (res > 255) ? 1 : 0; res = res & 255; end
            1, 4: begin res = (a - b) & 255; m_c = (a >= b) ? 1 : 0; end
            2: begin res = a & b; m_c = ((a + b) > 255) ? 1 : 0; end
            3: begin res = a | b; m_c = ((a + b) > 255) ? 1 : 0; end
            5: begin res = a; m_c = 0; end
            6: begin m_r[rd] = imm; return; end
            default: return;
        endcase
        m_z = (res == 0) ? 1 : 0;
        if (op != 4) m_r[rd] = res;
    endtask

    task automatic check_state(input string pfx);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk($sformatf("%s_R%0d", pfx, i), {24'b0, dbg_data}, m_r[i]);
        end
        chk({pfx, "_C"}, {31'b0, flag_c}, m_c);
        chk({pfx, "_Z"}, {31'b0, flag_z}, m_z);
    endtask

    task automatic rd_reg(input int idx, output logic [WIDTH-1:0] v);
        dbg_addr = 2'(idx);
        #1;
        v = dbg_data;
    endtask

    // Expected ALU drive in EXEC, taken from the opcode table using current model contents.
    task automatic check_alu_drive(input int op, input int rs1, input int rs2);
        int ea = 0, eb = 0, ec = 0, es = 0;
        case (op)
            0: begin ea = m_r[rs1]; eb = m_r[rs2]; ec = 0; es = 2; end
            1, 4: begin ea = m_r[rs1]; eb = m_r[rs2]; ec = 1; es = 2; end
            2: begin ea = m_r[rs1]; eb = m_r[rs2]; ec = 0; es = 0; end
            3: begin ea = m_r[rs1]; eb = m_r[rs2]; ec = 0; es = 1; end
            5: begin ea = m_r[rs1]; eb = 0; ec = 0; es = 2; end
            default: begin ea = 0; eb = 0; ec = 0; es = 0; end
        endcase
        chk("exec_alu_a", {24'b0, alu_a}, ea);
        chk("exec_alu_b", {24'b0, alu_b}, eb);
        chk("exec_ctrl", {30'b0, alu_ctrl}, ec);
        chk("exec_ctrl2", {29'b0, alu_ctrl2}, es);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (in_ready !== 1'b1) chk("ready_timeout", {31'b0, in_ready}, 1);
    endtask

    task automatic run_instr(input int op, input int rd, input int rs1, input int rs2, input int imm);
        wait_ready();
        in_op = 3'(op); in_rd = 2'(rd); in_rs1 = 2'(rs1); in_rs2 = 2'(rs2); in_imm = 8'(imm);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_imm = 8'($urandom);
        chk("exec_ready", {31'b0, in_ready}, 0);
        chk("exec_done", {31'b0, done}, 0);
        check_alu_drive(op, rs1, rs2);
        model_step(op, rd, rs1, rs2, imm);
        @(posedge clk); #1;
        chk("wb_done", {31'b0, done}, 1);
        chk("wb_ready", {31'b0, in_ready}, 0);
        check_state("wb");
        @(posedge clk); #1;
        chk("idle_ready", {31'b0, in_ready}, 1);
        chk("idle_done", {31'b0, done}, 0);
        chk("idle_alu_ctrl2", {29'b0, alu_ctrl2}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    logic [WIDTH-1:0] v;
    int base;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; dbg_addr = '0;
        do_reset();
        chk("rst_ready", {31'b0, in_ready}, 1);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_alu_a", {24'b0, alu_a}, 0);
        chk("rst_alu_b", {24'b0, alu_b}, 0);
        chk("rst_ctrl", {30'b0, alu_ctrl}, 0);
        check_state("rst");

        // SUB without borrow
        run_instr(6, 1, 0, 0, 8'h05);
        run_instr(6, 2, 0, 0, 8'h03);
        run_instr(1, 3, 1, 2, 0);
        rd_reg(3, v);
        chk("sub1_R3", {24'b0, v}, 32'h02);
        chk("sub1_C", {31'b0, flag_c}, 1);
        chk("sub1_Z", {31'b0, flag_z}, 0);

        // SUB with borrow
        run_instr(6, 1, 0, 0, 8'h03);
        run_instr(6, 2, 0, 0, 8'h05);
        run_instr(1, 0, 1, 2, 0);
        rd_reg(0, v);
        chk("sub2_R0", {24'b0, v}, 32'hFE);
        chk("sub2_C", {31'b0, flag_c}, 0);
        chk("sub2_Z", {31'b0, flag_z}, 0);

        // ADD wrap with rd == rs1
        run_instr(6, 1, 0, 0, 8'hFF);
        run_instr(6, 2, 0, 0, 8'h01);
        run_instr(0, 1, 1, 2, 0);
        rd_reg(1, v);
        chk("add_R1", {24'b0, v}, 32'h00);
        chk("add_C", {31'b0, flag_c}, 1);
        chk("add_Z", {31'b0, flag_z}, 1);

        // CMP, then AND/OR against complementary pattern
        run_instr(6, 1, 0, 0, 8'h3C);
        run_instr(6, 2, 0, 0, 8'h3C);
        run_instr(4, 0, 1, 2, 0);
        chk("cmp_C", {31'b0, flag_c}, 1);
        chk("cmp_Z", {31'b0, flag_z}, 1);
        run_instr(6, 2, 0, 0, 8'hC3);
        run_instr(2, 3, 1, 2, 0);
        rd_reg(3, v);
        chk("and_R3", {24'b0, v}, 32'h00);
        chk("and_Z", {31'b0, flag_z}, 1);
        run_instr(3, 3, 1, 2, 0);
        rd_reg(3, v);
        chk("or_R3", {24'b0, v}, 32'hFF);
        chk("or_Z", {31'b0, flag_z}, 0);
        run_instr(7, 0, 0, 0, 0);
        run_instr(5, 0, 3, 0, 0);

        // in_valid held high: ready pattern 1,0,0 and one retirement per instruction
        base = done_cnt;
        in_valid = 1'b1;
        in_op = 3'($urandom_range(0, 7)); in_rd = 2'($urandom); in_rs1 = 2'($urandom);
        in_rs2 = 2'($urandom); in_imm = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            chk("bb_ready1", {31'b0, in_ready}, 1);
            @(posedge clk); #1;
            chk("bb_ready0a", {31'b0, in_ready}, 0);
            model_step(in_op, in_rd, in_rs1, in_rs2, in_imm);
            @(posedge clk); #1;
            chk("bb_ready0b", {31'b0, in_ready}, 0);
            chk("bb_done", {31'b0, done}, 1);
            if (i < 5) begin
                in_op = 3'($urandom_range(0, 7)); in_rd = 2'($urandom); in_rs1 = 2'($urandom);
                in_rs2 = 2'($urandom); in_imm = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("bb_done_count", done_cnt - base, 6);
        check_state("bb");

        // Random instruction stream with idle gaps
        for (int i = 0; i < 60; i++) begin
            run_instr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        // Reset during EXEC of an ADD aborts it
        do_reset();
        run_instr(6, 1, 0, 0, 8'h10);
        run_instr(6, 2, 0, 0, 8'h20);
        in_op = 3'b000; in_rd = 2'd3; in_rs1 = 2'd1; in_rs2 = 2'd2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        base = done_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("abort_ready", {31'b0, in_ready}, 1);
        chk("abort_done", {31'b0, done}, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_done_count", done_cnt - base, 0);
        check_state("abort");

        // Reset wins over a simultaneous transfer
        run_instr(6, 2, 0, 0, 8'h77);
        in_op = 3'b110; in_rd = 2'd1; in_imm = 8'h55;
        in_valid = 1'b1;
        reset = 1'b1;
        base = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        model_reset();
        chk("prio_ready", {31'b0, in_ready}, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("prio_done_count", done_cnt - base, 0);
        check_state("prio");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: datapath width of the register file, immediate and ALU operand/result ports. Only 8 is required to be supported.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  instruction offered on in_op, in_rd, in_rs1, in_rs2 and in_imm.
REQ-005 in_ready  output  1  sequencer can accept an instruction this cycle.
REQ-006 in_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 CMP, 101 MOV, 110 LDI, 111 NOP.
REQ-007 in_rd, in_rs1, in_rs2  input  2 each  destination and source register indices (R0..R3).
REQ-008 in_imm  input  WIDTH  immediate value for LDI.
REQ-009 alu_a, alu_b  output  WIDTH each  operands driven to the ALU.
REQ-010 alu_ctrl  output  2  ALU invert/carry-in control; bit 0 = 1 selects subtract.
REQ-011 alu_ctrl2  output  3  ALU result select: 000 AND, 001 OR, 010 adder.
REQ-012 alu_y  input  WIDTH  ALU result.
REQ-013 alu_cout  input  1  ALU carry-out (bit 0 of the ALU cout port).
REQ-014 alu_zero  input  1  ALU zero flag (bit 0 of the ALU z port).
REQ-015 done  output  1  one-cycle pulse when an instruction retires.
REQ-016 flag_c, flag_z  output  1 each  registered carry and zero flags.
REQ-017 dbg_addr  input  2  register-file debug read index.
REQ-018 dbg_data  output  WIDTH  combinational value of R[dbg_addr].

Function
REQ-019 The sequencer SHALL hold four WIDTH-bit registers R0..R3; all four are writable and none is hardwired.
REQ-020 The FSM SHALL have three states, IDLE -> EXEC -> WB -> IDLE, with one cycle in each of EXEC and WB.
- IDLE: in_ready=1.
- EXEC and WB: in_ready=0.
REQ-021 A transfer occurs when in_valid && in_ready at a rising edge.
- On a transfer the sequencer latches the instruction and moves to EXEC.
- in_valid while in_ready=0 SHALL be ignored; the initiator holds the instruction until it is accepted.
REQ-022 In EXEC the sequencer SHALL drive the ALU outputs from registered values per opcode.
- ADD: a=R[rs1], b=R[rs2], ctrl=00, ctrl2=010.
- SUB and CMP: a=R[rs1], b=R[rs2], ctrl=01, ctrl2=010.
- AND: ctrl=00, ctrl2=000.
- OR: ctrl=00, ctrl2=001.
- MOV: a=R[rs1], b=0, ctrl=00, ctrl2=010.
REQ-023 Outside EXEC, and in EXEC for LDI or NOP, the sequencer SHALL drive alu_a=0, alu_b=0, alu_ctrl=00 and alu_ctrl2=000.
REQ-024 At the end of EXEC the sequencer SHALL update state per opcode.
- ADD, SUB, AND, OR, MOV: R[rd]<=alu_y, flag_c<=alu_cout, flag_z<=alu_zero.
- CMP: flags are updated, no register is written.
- LDI: R[rd]<=in_imm, flags unchanged.
- NOP: no state change.
REQ-025 Carry semantics SHALL follow the ALU.
- For SUB/CMP, C=1 means no borrow (R[rs1] >= R[rs2] unsigned).
- For AND/OR, the sampled alu_cout is stored as-is.
REQ-026 done SHALL be 1 exactly during WB, for all opcodes including NOP.
REQ-027 Latency: a transfer at edge T gives EXEC in cycle T+1 and done=1 in cycle T+2. A new transfer is possible at the edge ending cycle T+3. Throughput is one instruction per 3 cycles.
REQ-028 The destination register and flags SHALL be visible on dbg_data and flag_c/flag_z in WB, i.e. the same cycle as done.
REQ-029 A source equal to the destination (e.g. rd=rs1) SHALL use the pre-write value.

Reset
REQ-030 While reset=1 at a rising edge, the sequencer SHALL apply these reset values:
- state=IDLE, R0..R3=0, flag_c=0, flag_z=0.
- done=0, in_ready=1 in the following cycle.
- ALU outputs at their REQ-023 values.
REQ-031 Reset asserted during EXEC or WB SHALL abort the instruction: no register or flag write, and no done pulse.
REQ-032 reset=1 SHALL take priority over a simultaneous transfer; the offered instruction is discarded.

Verification
REQ-033 The bench SHALL cover these directed scenarios, with the real ALU connected:
- LDI R1,5; LDI R2,3; SUB R3,R1,R2 -> R3=02, C=1, Z=0, done exactly 2 cycles after the SUB transfer.
- LDI R1,3; LDI R2,5; SUB R0,R1,R2 -> R0=FE, C=0, Z=0.
- LDI R1,FF; LDI R2,01; ADD R1,R1,R2 -> R1=00, C=1, Z=1.
- R1=R2=0x3C; CMP R1,R2 -> Z=1, C=1, R0..R3 unchanged; then AND/OR with R2=0xC3 -> 00 (Z=1) and FF (Z=0).
- in_valid held high continuously -> in_ready toggles 1,0,0 and each instruction is accepted exactly once (count done pulses = instructions issued).
- Reset asserted in the EXEC cycle of an ADD -> no done pulse, destination register still 0, in_ready=1 in the cycle after reset.
